// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// Holds the RV32I access-size codes and the responder FSM state encoding.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: load extract/extend, store merge, and
// misalignment / illegal-code fault detection for one RV32I access.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o,
    output logic [3:0]  byte_mask_o,
    output logic        fault_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] rep_s;

    // Select the addressed byte/halfword and extend it to a full load result
    always_comb begin
        byte_s      = 8'h00;
        half_s      = 16'h0000;
        load_data_o = 32'h0000_0000;
        case (addr_lo_i)
            2'b00:   byte_s = rword_i[7:0];
            2'b01:   byte_s = rword_i[15:8];
            2'b10:   byte_s = rword_i[23:16];
            2'b11:   byte_s = rword_i[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo_i[1]) begin
            half_s = rword_i[31:16];
        end else begin
            half_s = rword_i[15:0];
        end
        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_s[7]}}, byte_s};
            F3_H:    load_data_o = {{16{half_s[15]}}, half_s};
            F3_W:    load_data_o = rword_i;
            F3_BU:   load_data_o = {24'h00_0000, byte_s};
            F3_HU:   load_data_o = {16'h0000, half_s};
            default: load_data_o = 32'h0000_0000;
        endcase
    end

    // Replicate store data onto every lane, then keep only the addressed bytes
    always_comb begin
        rep_s        = 32'h0000_0000;
        byte_mask_o  = 4'b0000;
        store_word_o = rword_i;
        case (funct3_i)
            F3_B: begin
                rep_s       = {4{wdata_i[7:0]}};
                byte_mask_o = 4'b0001 << addr_lo_i;
            end
            F3_H: begin
                rep_s = {2{wdata_i[15:0]}};
                if (addr_lo_i[1]) begin
                    byte_mask_o = 4'b1100;
                end else begin
                    byte_mask_o = 4'b0011;
                end
            end
            F3_W: begin
                rep_s       = wdata_i;
                byte_mask_o = 4'b1111;
            end
            default: begin
                rep_s       = 32'h0000_0000;
                byte_mask_o = 4'b0000;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            if (byte_mask_o[i]) begin
                store_word_o[8*i +: 8] = rep_s[8*i +: 8];
            end else begin
                store_word_o[8*i +: 8] = rword_i[8*i +: 8];
            end
        end
    end

    // Reject misaligned accesses and codes that have no meaning for the direction
    always_comb begin
        fault_o = 1'b0;
        if (we_i) begin
            case (funct3_i)
                F3_B:    fault_o = 1'b0;
                F3_H:    fault_o = addr_lo_i[0];
                F3_W:    fault_o = (addr_lo_i != 2'b00);
                default: fault_o = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                F3_B, F3_BU: fault_o = 1'b0;
                F3_H, F3_HU: fault_o = addr_lo_i[0];
                F3_W:        fault_o = (addr_lo_i != 2'b00);
                default:     fault_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed wait states, an internal
// word array, RV32I sub-word access and fault reporting.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNTW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            fault_q, fault_d;

    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            accept_s;
    logic            enter_resp_s;
    logic            eff_we_s;
    logic [2:0]      eff_funct3_s;
    logic [31:0]     eff_addr_s;
    logic [31:0]     eff_wdata_s;
    logic [IDXW-1:0] idx_s;
    logic [31:0]     rword_s;
    logic            range_fault_s;
    logic            lane_fault_s;
    logic            fault_s;
    logic [31:0]     load_data_s;
    logic [31:0]     store_word_s;
    logic [3:0]      byte_mask_s;

    assign req_ready = (state_q == IDLE) & ~reset;
    assign accept_s  = req_valid & req_ready;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_fault = fault_q;

    // With zero wait states the access completes on the accept edge, so the
    // datapath works from the live request while idle and the latch otherwise.
    always_comb begin
        if (state_q == IDLE) begin
            eff_we_s     = req_we;
            eff_funct3_s = req_funct3;
            eff_addr_s   = req_addr;
            eff_wdata_s  = req_wdata;
        end else begin
            eff_we_s     = we_q;
            eff_funct3_s = funct3_q;
            eff_addr_s   = addr_q;
            eff_wdata_s  = wdata_q;
        end
    end

    assign idx_s         = eff_addr_s[IDXW+1:2];
    assign rword_s       = mem_q[idx_s];
    assign range_fault_s = ({2'b00, eff_addr_s[31:2]} >= 32'(DEPTH_WORDS));
    assign fault_s       = lane_fault_s | range_fault_s;

    dmem_lane_align u_lane_align (
        .we_i         (eff_we_s),
        .funct3_i     (eff_funct3_s),
        .addr_lo_i    (eff_addr_s[1:0]),
        .rword_i      (rword_s),
        .wdata_i      (eff_wdata_s),
        .load_data_o  (load_data_s),
        .store_word_o (store_word_s),
        .byte_mask_o  (byte_mask_s),
        .fault_o      (lane_fault_s)
    );

    // Next-state, wait counter, request latch and response capture
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        fault_d      = fault_q;
        enter_resp_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (LATENCY == 0) begin
                        state_d      = RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNTW'(LATENCY - 1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == {CNTW{1'b0}}) begin
                    state_d      = RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (enter_resp_s) begin
            fault_d = fault_s;
            if (fault_s || eff_we_s) begin
                rdata_d = 32'h0000_0000;
            end else begin
                rdata_d = load_data_s;
            end
        end else begin
            fault_d = fault_q;
        end
    end

    // Control and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= {CNTW{1'b0}};
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0000_0000;
            wdata_q  <= 32'h0000_0000;
            rdata_q  <= 32'h0000_0000;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    // Array commit on the response-entry edge; reset on that edge suppresses it
    always_ff @(posedge clk) begin
        if (!reset && enter_resp_s && eff_we_s && !fault_s && (byte_mask_s != 4'b0000)) begin
            mem_q[idx_s] <= store_word_s;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=2 and LATENCY=0).
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, rsp_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_fault;
    logic [31:0] rsp_rdata;

    logic        req_valid0, req_we0, rsp_ready0;
    logic [2:0]  req_funct30;
    logic [31:0] req_addr0, req_wdata0;
    logic        req_ready0, rsp_valid0, rsp_fault0;
    logic [31:0] rsp_rdata0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_funct3(req_funct30), .req_addr(req_addr0), .req_wdata(req_wdata0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_rdata(rsp_rdata0), .rsp_fault(rsp_fault0)
    );

    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic flt, output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        rd = rsp_rdata; flt = rsp_fault;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic xact0(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd,
                         output logic flt, output int lat);
        @(negedge clk);
        req_valid0 = 1'b1; req_we0 = we; req_funct30 = f3; req_addr0 = addr; req_wdata0 = wd;
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        lat = 0;
        while (rsp_valid0 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        rd = rsp_rdata0; flt = rsp_fault0;
        rsp_ready0 = 1'b1;
        @(posedge clk); #1;
        rsp_ready0 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
        n_cmp++; if (rsp_fault !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_fault got %b want 0", rsp_fault); end
        @(negedge clk); reset = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_req_ready got %b want 1", req_ready); end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic flt; int lat;
        xact(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd, flt, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL sw_latency got %0d want 2", lat); end
        n_cmp++; if (flt !== 1'b0 || rd !== 32'h0) begin n_bad++; $display("FAIL sw_rsp got %h/%b want 0/0", rd, flt); end
        xact(1'b0, 3'b010, 32'h10, 32'h0, rd, flt, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL lw_latency got %0d want 2", lat); end
        n_cmp++; if (rd !== 32'hDEAD_BEEF || flt !== 1'b0) begin n_bad++; $display("FAIL lw_data got %h/%b want deadbeef/0", rd, flt); end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic flt; int lat;
        xact(1'b1, 3'b010, 32'h10, 32'h0, rd, flt, lat);
        xact(1'b1, 3'b000, 32'h11, 32'h1234_5680, rd, flt, lat);
        n_cmp++; if (flt !== 1'b0) begin n_bad++; $display("FAIL sb_fault got %b want 0", flt); end
        xact(1'b0, 3'b000, 32'h11, 32'h0, rd, flt, lat);
        n_cmp++; if (rd !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb got %h want ffffff80", rd); end
        xact(1'b0, 3'b100, 32'h11, 32'h0, rd, flt, lat);
        n_cmp++; if (rd !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu got %h want 00000080", rd); end
        xact(1'b0, 3'b010, 32'h10, 32'h0, rd, flt, lat);
        n_cmp++; if (rd !== 32'h0000_8000) begin n_bad++; $display("FAIL lw_after_sb got %h want 00008000", rd); end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic flt; int lat;
        xact(1'b1, 3'b010, 32'h20, 32'h0000_AAAA, rd, flt, lat);
        xact(1'b1, 3'b001, 32'h22, 32'h0000_8001, rd, flt, lat);
        xact(1'b0, 3'b001, 32'h22, 32'h0, rd, flt, lat);
        n_cmp++; if (rd !== 32'hFFFF_8001) begin n_bad++; $display("FAIL lh got %h want ffff8001", rd); end
        xact(1'b0, 3'b101, 32'h22, 32'h0, rd, flt, lat);
        n_cmp++; if (rd !== 32'h0000_8001) begin n_bad++; $display("FAIL lhu got %h want 00008001", rd); end
        xact(1'b0, 3'b010, 32'h20, 32'h0, rd, flt, lat);
        n_cmp++; if (rd !== 32'h8001_AAAA) begin n_bad++; $display("FAIL lw_after_sh got %h want 8001aaaa", rd); end
    endtask

    task automatic test_fault();
        logic [31:0] rd; logic flt; int lat;
        xact(1'b0, 3'b010, 32'h13, 32'h0, rd, flt, lat);
        n_cmp++; if (flt !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL lw_misaligned got %h/%b want 0/1", rd, flt); end
        xact(1'b1, 3'b001, 32'h21, 32'h0000_FFFF, rd, flt, lat);
        n_cmp++; if (flt !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL sh_misaligned got %h/%b want 0/1", rd, flt); end
        xact(1'b0, 3'b010, 32'h20, 32'h0, rd, flt, lat);
        n_cmp++; if (rd !== 32'h8001_AAAA) begin n_bad++; $display("FAIL sh_fault_side_effect got %h want 8001aaaa", rd); end
        xact(1'b0, 3'b011, 32'h20, 32'h0, rd, flt, lat);
        n_cmp++; if (flt !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL load_f3_011 got %h/%b want 0/1", rd, flt); end
        xact(1'b1, 3'b100, 32'h20, 32'h0, rd, flt, lat);
        n_cmp++; if (flt !== 1'b1) begin n_bad++; $display("FAIL store_f3_100 got %b want 1", flt); end
        xact(1'b1, 3'b010, 32'h0, 32'h1111_1111, rd, flt, lat);
        xact(1'b1, 3'b010, 32'h400, 32'hBAD0_BAD0, rd, flt, lat);
        n_cmp++; if (flt !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL sw_out_of_range got %h/%b want 0/1", rd, flt); end
        xact(1'b0, 3'b010, 32'h0, 32'h0, rd, flt, lat);
        n_cmp++; if (rd !== 32'h1111_1111 || flt !== 1'b0) begin n_bad++; $display("FAIL alias_unchanged got %h/%b want 11111111/0", rd, flt); end
    endtask

    task automatic test_backpressure();
        int lat; int bad_cycles;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL bp_latency got %0d want 2", lat); end
        // A competing request during the stall must not be taken
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF;
        bad_cycles = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_8000 || req_ready !== 1'b0) bad_cycles++;
        end
        n_cmp++; if (bad_cycles !== 0) begin n_bad++; $display("FAIL bp_hold got %0d bad cycles want 0", bad_cycles); end
        req_valid = 1'b0;
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
        repeat (3) @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_extra_rsp got %b want 0", rsp_valid); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic flt; int lat;
        xact(1'b1, 3'b010, 32'h30, 32'h5555_5555, rd, flt, lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        repeat (4) @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wait got valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
        xact(1'b0, 3'b010, 32'h30, 32'h0, rd, flt, lat);
        n_cmp++; if (rd !== 32'h5555_5555) begin n_bad++; $display("FAIL reset_wait_no_store got %h want 55555555", rd); end
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'h1212_1212;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_edge got valid=%b want 0", rsp_valid); end
        @(negedge clk); reset = 1'b0;
        xact(1'b0, 3'b010, 32'h30, 32'h0, rd, flt, lat);
        n_cmp++; if (rd !== 32'h5555_5555) begin n_bad++; $display("FAIL reset_edge_no_store got %h want 55555555", rd); end
    endtask

    task automatic test_lat0();
        logic [31:0] rd; logic flt; int lat;
        xact0(1'b1, 3'b010, 32'h40, 32'h0BAD_CAFE, rd, flt, lat);
        n_cmp++; if (lat !== 0 || flt !== 1'b0) begin n_bad++; $display("FAIL lat0_sw got lat=%0d flt=%b want 0/0", lat, flt); end
        xact0(1'b0, 3'b010, 32'h40, 32'h0, rd, flt, lat);
        n_cmp++; if (lat !== 0 || rd !== 32'h0BAD_CAFE) begin n_bad++; $display("FAIL lat0_lw got lat=%0d %h want 0/0badcafe", lat, rd); end
        xact0(1'b0, 3'b100, 32'h43, 32'h0, rd, flt, lat);
        n_cmp++; if (rd !== 32'h0000_000B) begin n_bad++; $display("FAIL lat0_lbu got %h want 0000000b", rd); end
        xact0(1'b0, 3'b001, 32'h41, 32'h0, rd, flt, lat);
        n_cmp++; if (flt !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL lat0_lh_misaligned got %h/%b want 0/1", rd, flt); end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_funct30 = 3'b000; req_addr0 = 32'h0; req_wdata0 = 32'h0; rsp_ready0 = 1'b0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_fault();
        test_backpressure();
        test_reset_mid();
        test_lat0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the core's load/store port: accepts one request at a time over a valid/ready handshake.
- Models a fixed, configurable number of wait states.
- Performs RV32I byte/halfword/word access with sign/zero extension and store byte-merging.
- Returns read data, or a fault for misaligned, illegal or out-of-range accesses.
- Sits between the core's memory port (address, store data, load data) and a word-organised RAM array held inside this block.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array; legal word index is 0..DEPTH_WORDS-1.
- LATENCY, 2, wait-state cycles between request acceptance and response (0 allowed).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I access size/sign code.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  core accepts response.
- rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and faults.
- rsp_fault  output  1  access rejected; no memory side effect.

Behaviour:
- States: IDLE, WAIT, RESP.
- req_ready = (state==IDLE) & ~reset.
- Accept when req_valid & req_ready. Latch we, funct3, addr and wdata in the accept cycle.
- Transitions:
  - IDLE -> WAIT on accept if LATENCY>0; the counter loads LATENCY-1.
  - IDLE -> RESP on accept if LATENCY==0.
  - WAIT decrements the counter; WAIT -> RESP when the counter is 0.
- Latency: accept at edge N, so rsp_valid is high from cycle N+1+LATENCY.
- RESP holds rsp_valid=1 with rsp_rdata/rsp_fault stable until rsp_ready. RESP -> IDLE on rsp_valid & rsp_ready.
- Minimum spacing between accepts is LATENCY+2 cycles. No pipelining; at most one outstanding request.
- Store commit: the array is written on the edge that enters RESP, only if there is no fault.
- Load read: data is captured into the response register on the edge that enters RESP.
- Load codes (funct3): 000 LB sign-ext, 001 LH sign-ext, 010 LW, 100 LBU zero-ext, 101 LHU zero-ext.
- Store codes (funct3): 000 SB, 001 SH, 010 SW.
- Byte lane is addr[1:0]; halfword lane is addr[1]. Little-endian.
- SB/SH modify only the addressed bytes; other bytes of the word are preserved.
- Fault conditions:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Load funct3 in {011,110,111}.
  - Store funct3 >= 011.
  - Word index addr[31:2] >= DEPTH_WORDS.
  - On fault: rsp_fault=1, rsp_rdata=0, array unchanged.
- Reset values: state IDLE, counter 0, rsp_valid=0, rsp_rdata=0, rsp_fault=0, latched request cleared.
- Array contents are not reset.
- Reset mid-operation returns to IDLE and discards the pending request.
- If reset coincides with the RESP-entry edge, reset wins and no store is committed.
- A request presented while not in IDLE is not accepted. The core must hold req_* stable until accepted.
- A load issued after a store's response handshake returns the stored data.

Decomposition:
- Shared package dmem_pkg contains:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum: IDLE, WAIT, RESP.
- Sub-module dmem_lane_align (combinational) contains:
  - Load extract/extend from a 32-bit word, funct3 and addr[1:0].
  - Store merge producing new word and byte mask.
  - Misalignment/illegal-code fault detection.
- The FSM, counter, array and range check live in dmem_responder.

Test Plan:
- SW then LW: addr 0x10, wdata 0xDEADBEEF, LATENCY=2 → rsp_valid exactly 3 cycles after each accept; load returns 0xDEADBEEF, rsp_fault=0.
- SB then LB/LBU/LW:
  - SB 0x80 to addr 0x11 over word 0x00000000.
  - LB 0x11 → 0xFFFFFF80; LBU 0x11 → 0x00000080; LW 0x10 → 0x00008000.
- Halfword extension: SH 0x8001 to 0x22, then LH 0x22 → 0xFFFF8001 and LHU 0x22 → 0x00008001.
- Faults, each with rsp_fault=1 and rsp_rdata=0:
  - LW 0x13; SH 0x21; load funct3 011.
  - SW to addr 4*DEPTH_WORDS; a following LW of that word's in-range alias (word 0) shows prior contents unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid and data stable, req_ready=0 throughout; rsp_ready=1 → IDLE the next cycle, req_ready=1.
- Reset/latency corner cases:
  - Assert reset during WAIT of an SW to 0x30 → no response; subsequent LW 0x30 returns the pre-store value.
  - With LATENCY=0, rsp_valid is high the cycle after accept.
